pattern_scan_ctrl: RTL and testbench

PATTERN_SCAN_CTRL -- requirements
Module: pattern_scan_ctrl

---
 rtl/pattern_scan_ctrl_pkg.sv | 9 +
 rtl/pattern_match_core.sv | 37 +++
 rtl/pattern_scan_ctrl.sv | 76 +++++++
 tb/tb_pattern_scan_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/pattern_scan_ctrl_pkg.sv
// pattern_scan_ctrl_pkg: shared state encoding, default widths and config check
package pattern_scan_ctrl_pkg;
  localparam int PAT_W_DEF = 8;
  localparam int CNT_W_DEF = 8;
  typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_e;
  function automatic logic len_ok(input logic [3:0] len, input int w);
    return len != 4'd0 && int'(len) <= w;
  endfunction
endpackage

// File: rtl/pattern_match_core.sv
// pattern_match_core: history shift register, fill counter, masked compare and registered match
module pattern_match_core #(
  parameter int PAT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             x_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic [3:0]       len_i,
  output logic             hit_o,
  output logic             match_o
);
  localparam int FW = $clog2(PAT_W + 1);
  logic [PAT_W-1:0] hist_q, hist_d, mask;
  logic [FW-1:0]    fill_q, fill_d;
  logic             match_q;
  assign hist_d  = {hist_q[PAT_W-2:0], x_i};
  assign fill_d  = (fill_q == FW'(PAT_W)) ? fill_q : fill_q + 1'b1;
  assign mask    = PAT_W'((32'd1 << len_i) - 32'd1);
  assign hit_o   = en_i && (int'(fill_d) >= int'(len_i)) && (((hist_d ^ pat_i) & mask) == '0);
  assign match_o = match_q;
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
    end else begin
      match_q <= hit_o;
      if (en_i) begin
        hist_q <= hist_d;
        fill_q <= fill_d;
      end
    end
  end
endmodule

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: scan FSM, configuration latch and saturating hit counter
module pattern_scan_ctrl
  import pattern_scan_ctrl_pkg::*;
#(
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pat,
  input  logic [3:0]       pat_len,
  input  logic [CNT_W-1:0] max_hits,
  input  logic             x,
  input  logic             x_valid,
  input  logic             stop,
  output logic             busy,
  output logic             y,
  output logic [CNT_W-1:0] hit_cnt,
  output logic             done,
  output logic             err
);
  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q;
  logic [3:0]       len_q;
  logic [CNT_W-1:0] max_q, hit_cnt_q, hit_cnt_d, cnt_inc;
  logic             err_q, err_d, hit, limit, cfg_ok;
  pattern_match_core #(.PAT_W(PAT_W)) u_core (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (state_q == LOAD),
    .en_i    (state_q == SCAN && x_valid),
    .x_i     (x),
    .pat_i   (pat_q),
    .len_i   (len_q),
    .hit_o   (hit),
    .match_o (y)
  );
  assign cfg_ok  = len_ok(pat_len, PAT_W);
  assign cnt_inc = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + 1'b1;
  assign limit   = hit && max_q != '0 && cnt_inc == max_q;
  assign busy    = state_q == LOAD || state_q == SCAN;
  assign done    = state_q == DONE;
  assign err     = err_q;
  assign hit_cnt = hit_cnt_q;
  always_comb begin
    state_d   = state_q;
    err_d     = state_q == IDLE && start && !cfg_ok;
    hit_cnt_d = (state_q == LOAD) ? '0 : hit ? cnt_inc : hit_cnt_q;
    case (state_q)
      IDLE:    state_d = (start && cfg_ok) ? LOAD : IDLE;
      LOAD:    state_d = SCAN;
      SCAN:    state_d = (stop || limit) ? DONE : SCAN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      max_q     <= '0;
      hit_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      hit_cnt_q <= hit_cnt_d;
      err_q     <= err_d;
      if (state_q == IDLE && start && cfg_ok) begin
        pat_q <= pat;
        len_q <= pat_len;
        max_q <= max_hits;
      end
    end
  end
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: directed and random stimulus checked against a bit-queue reference model
module tb_pattern_scan_ctrl;
  logic       clk = 0, rst = 1, start = 0, x = 0, x_valid = 0, stop = 0;
  logic [7:0] pat = 0, max_hits = 0;
  logic [3:0] pat_len = 0;
  logic       busy, y, done, err;
  logic [7:0] hit_cnt;
  int         n_checks = 0, n_errors = 0, y_seen = 0, y0;
  int         m_phase = 0, m_len = 0, m_max = 0, m_cnt = 0;
  logic [7:0] m_pat = 0;
  bit         m_y = 0, m_err = 0;
  bit         hist[$];
  pattern_scan_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .pat(pat), .pat_len(pat_len),
    .max_hits(max_hits), .x(x), .x_valid(x_valid), .stop(stop),
    .busy(busy), .y(y), .hit_cnt(hit_cnt), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask
  function automatic bit tail_matches();
    if (hist.size() < m_len) return 0;
    for (int i = 0; i < m_len; i++)
      if (hist[hist.size() - 1 - i] != m_pat[i]) return 0;
    return 1;
  endfunction
  task automatic model(input bit s, input bit xb, input bit xv, input bit sp, input bit r);
    m_y = 0;
    m_err = 0;
    if (r) begin
      m_phase = 0;
      m_cnt = 0;
      m_len = 0;
      m_max = 0;
      hist.delete();
    end else if (m_phase == 0) begin
      if (s && pat_len >= 1 && pat_len <= 8) begin
        m_pat = pat;
        m_len = int'(pat_len);
        m_max = int'(max_hits);
        m_phase = 1;
      end else if (s) m_err = 1;
    end else if (m_phase == 1) begin
      hist.delete();
      m_cnt = 0;
      m_phase = 2;
    end else if (m_phase == 2) begin
      if (xv) begin
        hist.push_back(xb);
        if (tail_matches()) begin
          m_y = 1;
          if (m_cnt < 255) m_cnt++;
          if (m_max != 0 && m_cnt == m_max) m_phase = 3;
        end
      end
      if (sp) m_phase = 3;
    end else m_phase = 0;
  endtask
  task automatic cyc(input bit s, input bit xb, input bit xv, input bit sp, input bit r);
    start = s;
    x = xb;
    x_valid = xv;
    stop = sp;
    rst = r;
    @(posedge clk);
    model(s, xb, xv, sp, r);
    #1;
    y_seen += int'(y);
    check("y", int'(y), int'(m_y));
    check("hit_cnt", int'(hit_cnt), m_cnt);
    check("busy", int'(busy), int'(m_phase == 1 || m_phase == 2));
    check("done", int'(done), int'(m_phase == 3));
    check("err", int'(err), int'(m_err));
    @(negedge clk);
  endtask
  task automatic begin_scan(input logic [7:0] p, input logic [3:0] l, input logic [7:0] m);
    pat = p;
    pat_len = l;
    max_hits = m;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
  endtask
  task automatic feed(input bit b);
    cyc(0, b, 1, 0, 0);
  endtask
  initial begin
    logic [12:0] s1;
    @(negedge clk);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    check("reset_hit_cnt", int'(hit_cnt), 0);
    // overlapping 110 pattern, unlimited hits, ended by stop
    s1 = 13'b1101101101011;
    begin_scan(8'b110, 3, 0);
    y0 = y_seen;
    for (int i = 12; i >= 0; i--) feed(s1[i]);
    cyc(0, 0, 0, 1, 0);
    check("s1_hit_cnt", int'(hit_cnt), 3);
    check("s1_done", int'(done), 1);
    check("s1_ycount", y_seen - y0, 3);
    cyc(0, 0, 0, 0, 0);
    // hit limit of 2 ends the scan, 4th bit falls into DONE
    begin_scan(8'b11, 2, 2);
    for (int i = 0; i < 4; i++) feed(1);
    check("s2_hit_cnt", int'(hit_cnt), 2);
    cyc(0, 0, 0, 0, 0);
    // gaps between valid bits
    begin_scan(8'b110, 3, 0);
    y0 = y_seen;
    feed(1); cyc(0, 0, 0, 0, 0); cyc(0, 1, 0, 0, 0);
    feed(1); cyc(0, 0, 0, 0, 0);
    feed(0); cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("s3_ycount", y_seen - y0, 1);
    cyc(0, 0, 0, 0, 0);
    // illegal lengths
    pat_len = 0; cyc(1, 0, 0, 0, 0); cyc(0, 0, 0, 0, 0);
    pat_len = 9; cyc(1, 0, 0, 0, 0);
    check("s4_err", int'(err), 1);
    check("s4_busy", int'(busy), 0);
    cyc(0, 0, 0, 0, 0);
    // reset mid-scan after two hits
    begin_scan(8'b11, 2, 0);
    feed(1); feed(1); feed(1);
    cyc(1, 0, 0, 1, 1);
    check("s5_hit_cnt", int'(hit_cnt), 0);
    cyc(0, 0, 0, 0, 0);
    // restart attempt and config change during scan
    begin_scan(8'b101, 3, 0);
    pat = 8'b111;
    pat_len = 2;
    y0 = y_seen;
    cyc(1, 1, 1, 0, 0);
    feed(0); feed(1); feed(1); feed(1);
    cyc(1, 0, 0, 1, 0);
    check("s6_ycount", y_seen - y0, 1);
    check("s6_hit_cnt", int'(hit_cnt), 1);
    cyc(0, 0, 0, 0, 0);
    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        pat = 8'($urandom);
        pat_len = 4'($urandom_range(0, 9));
        max_hits = 8'($urandom_range(0, 3));
      end
      cyc($urandom_range(0, 7) == 0, 1'($urandom), $urandom_range(0, 3) != 0,
          $urandom_range(0, 31) == 0, $urandom_range(0, 127) == 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
